// File: rtl/float_to_fixed_seq.sv
// Sequential float-to-fixed converter: classifies the captured operand, then shifts the
// significand one bit per cycle toward a runtime-selected radix point.

module SpecialCases #(
    parameter int EXPONENTBITS = 8,
    parameter int MANTISSABITS = 23
) (
    input  logic [EXPONENTBITS+MANTISSABITS-1:0] i_magnitude,
    output logic                                 o_exception,
    output logic                                 o_zero,
    output logic                                 o_normal
);
    logic [EXPONENTBITS-1:0] w_exp;
    logic [MANTISSABITS-1:0] w_mant;

    assign w_exp       = i_magnitude[EXPONENTBITS+MANTISSABITS-1:MANTISSABITS];
    assign w_mant      = i_magnitude[MANTISSABITS-1:0];
    assign o_exception = &w_exp;
    assign o_zero      = (w_exp == '0) && (w_mant == '0);
    assign o_normal    = (w_exp != '0) && !(&w_exp);
endmodule

module float_to_fixed_seq #(
    parameter int FLOATSIZE      = 32,
    parameter int FIXEDSIZE      = 32,
    parameter int RADIXPOINTSIZE = 6,
    parameter int EXPONENTBITS   = 8,
    parameter int MANTISSABITS   = 23
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic                      Start,
    input  logic [FLOATSIZE-1:0]      InFloat,
    input  logic [RADIXPOINTSIZE-1:0] InRadixPoint,
    output logic [FIXEDSIZE-1:0]      OutFixed,
    output logic                      OutDone,
    output logic                      OutBusy,
    output logic                      OutException,
    output logic                      OutZero,
    output logic                      OutOverflow
);
    localparam int SW        = EXPONENTBITS + RADIXPOINTSIZE + 2;
    localparam int BIAS      = 2**(EXPONENTBITS-1) - 1;
    localparam int SHIFT_MAX = FIXEDSIZE - 2 - MANTISSABITS;
    localparam int NMAX      = (SHIFT_MAX > MANTISSABITS) ? SHIFT_MAX : MANTISSABITS;
    localparam int NW        = $clog2(NMAX + 1);

    localparam logic signed [SW-1:0]   S_HI    = SW'(SHIFT_MAX);
    localparam logic signed [SW-1:0]   S_LO    = SW'(-MANTISSABITS);
    localparam logic [FIXEDSIZE-1:0]   SAT_POS = {1'b0, {(FIXEDSIZE-1){1'b1}}};
    localparam logic [FIXEDSIZE-1:0]   SAT_NEG = {1'b1, {(FIXEDSIZE-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CHECK, SHIFT, FINISH} state_t;
    typedef enum logic [1:0] {PATH_NORMAL, PATH_EXCEPTION, PATH_ZERO, PATH_OVERFLOW} path_t;

    state_t                    r_state, w_next;
    path_t                     r_path, w_path;
    logic                      w_underflow;
    logic [FLOATSIZE-1:0]      r_float;
    logic [RADIXPOINTSIZE-1:0] r_radix;
    logic [FIXEDSIZE-1:0]      r_mag, r_fixed;
    logic [NW-1:0]             r_count;
    logic                      r_left, r_done, r_busy;
    logic                      r_exception, r_zero, r_overflow;

    logic                      w_exception, w_zero, w_normal;
    logic [EXPONENTBITS-1:0]   w_exp;
    logic [FIXEDSIZE-1:0]      w_sig;
    logic signed [SW-1:0]      w_shift, w_shift_abs;

    SpecialCases #(
        .EXPONENTBITS (EXPONENTBITS),
        .MANTISSABITS (MANTISSABITS)
    ) u_special (
        .i_magnitude (r_float[EXPONENTBITS+MANTISSABITS-1:0]),
        .o_exception (w_exception),
        .o_zero      (w_zero),
        .o_normal    (w_normal)
    );

    assign w_exp       = r_float[FLOATSIZE-2 -: EXPONENTBITS];
    assign w_sig       = {{(FIXEDSIZE-MANTISSABITS-1){1'b0}}, 1'b1, r_float[MANTISSABITS-1:0]};
    assign w_shift     = $signed({{(SW-EXPONENTBITS){1'b0}}, w_exp})
                       + $signed({{(SW-RADIXPOINTSIZE){1'b0}}, r_radix})
                       - SW'(BIAS + MANTISSABITS);
    assign w_shift_abs = w_shift[SW-1] ? -w_shift : w_shift;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        w_next      = r_state;
        w_path      = PATH_NORMAL;
        w_underflow = 1'b0;
        case (r_state)
            IDLE:   if (Start) w_next = CHECK;
            CHECK: begin
                w_next = FINISH;
                if (w_exception)                w_path = PATH_EXCEPTION;
                else if (w_zero || !w_normal)   w_path = PATH_ZERO;
                else if (w_shift > S_HI)        w_path = PATH_OVERFLOW;
                else if (w_shift < S_LO)        w_underflow = 1'b1;
                else if (w_shift_abs != '0)     w_next = SHIFT;
            end
            SHIFT:  if (r_count == NW'(1)) w_next = FINISH;
            FINISH: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_path      <= PATH_NORMAL;
            r_float     <= '0;
            r_radix     <= '0;
            r_mag       <= '0;
            r_fixed     <= '0;
            r_count     <= '0;
            r_left      <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_exception <= 1'b0;
            r_zero      <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_done <= (r_state == FINISH);
            case (r_state)
                IDLE: begin
                    if (Start) begin
                        r_float     <= InFloat;
                        r_radix     <= InRadixPoint;
                        r_busy      <= 1'b1;
                        r_exception <= 1'b0;
                        r_zero      <= 1'b0;
                        r_overflow  <= 1'b0;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                CHECK: begin
                    r_path  <= w_path;
                    r_mag   <= w_underflow ? '0 : w_sig;
                    r_count <= w_shift_abs[NW-1:0];
                    r_left  <= !w_shift[SW-1];
                end
                SHIFT: begin
                    // Right shifts drop fraction bits, truncating the magnitude toward zero.
                    r_mag   <= r_left ? (r_mag << 1) : (r_mag >> 1);
                    r_count <= r_count - NW'(1);
                end
                FINISH: begin
                    r_exception <= (r_path == PATH_EXCEPTION);
                    r_zero      <= (r_path == PATH_ZERO);
                    r_overflow  <= (r_path == PATH_OVERFLOW);
                    case (r_path)
                        PATH_OVERFLOW:             r_fixed <= r_float[FLOATSIZE-1] ? SAT_NEG : SAT_POS;
                        PATH_EXCEPTION, PATH_ZERO: r_fixed <= '0;
                        default:                   r_fixed <= r_float[FLOATSIZE-1] ? -r_mag : r_mag;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign OutFixed     = r_fixed;
    assign OutDone      = r_done;
    assign OutBusy      = r_busy;
    assign OutException = r_exception;
    assign OutZero      = r_zero;
    assign OutOverflow  = r_overflow;
endmodule

// File: tb/tb_float_to_fixed_seq.sv
// Self-checking bench for float_to_fixed_seq: arithmetic reference model, per-cycle monitor,
// and hand-computed literals for the directed vectors.

module tb_float_to_fixed_seq;
    localparam int PERIOD = 10;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        Start = 1'b0;
    logic [31:0] InFloat = '0;
    logic [5:0]  InRadixPoint = '0;
    logic [31:0] OutFixed;
    logic        OutDone, OutBusy, OutException, OutZero, OutOverflow;

    float_to_fixed_seq dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .Start        (Start),
        .InFloat      (InFloat),
        .InRadixPoint (InRadixPoint),
        .OutFixed     (OutFixed),
        .OutDone      (OutDone),
        .OutBusy      (OutBusy),
        .OutException (OutException),
        .OutZero      (OutZero),
        .OutOverflow  (OutOverflow)
    );

    always #(PERIOD/2) Clk = ~Clk;

    typedef struct {
        logic [31:0] fixed;
        logic        exc;
        logic        zero;
        logic        ovf;
        int          lat;
        time         t;
    } exp_t;

    typedef struct {
        logic [31:0] f;
        logic [5:0]  r;
        logic [31:0] lit;
    } vec_t;

    exp_t q[$];
    vec_t vecs[16];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   running = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: real value times 2^R, truncated toward zero, saturated to 32-bit signed.
    function automatic exp_t model(input logic [31:0] f, input int r);
        exp_t        m;
        int          e;
        int          s;
        longint      sig;
        longint      mag;
        logic [31:0] low;
        e   = int'(f[30:23]);
        s   = e - 127 - 23 + r;
        sig = longint'({1'b1, f[22:0]});
        m.fixed = '0; m.exc = 1'b0; m.zero = 1'b0; m.ovf = 1'b0; m.lat = 2; m.t = 0;
        if (e == 255) begin
            m.exc = 1'b1;
        end else if (e == 0) begin
            m.zero = 1'b1;
        end else if (s > 7) begin
            m.ovf   = 1'b1;
            m.fixed = f[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else if (s >= -23) begin
            mag     = (s >= 0) ? (sig << s) : (sig >> (-s));
            low     = mag[31:0];
            m.fixed = f[31] ? -low : low;
            m.lat   = 2 + ((s >= 0) ? s : -s);
        end
        return m;
    endfunction

    always @(negedge Clk) begin
        exp_t e;
        if (running && !Rst) begin
            check("busy", {31'b0, OutBusy}, {31'b0, q.size() != 0});
            if (OutDone) begin
                if (q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("fixed",     OutFixed, e.fixed);
                    check("exception", {31'b0, OutException}, {31'b0, e.exc});
                    check("zero",      {31'b0, OutZero}, {31'b0, e.zero});
                    check("overflow",  {31'b0, OutOverflow}, {31'b0, e.ovf});
                    check("latency",   32'(($time - PERIOD/2 - e.t) / PERIOD), 32'(e.lat));
                end
            end
        end
    end

    task automatic start(input logic [31:0] f, input logic [5:0] r);
        exp_t m;
        @(negedge Clk);
        Start = 1'b1; InFloat = f; InRadixPoint = r;
        @(posedge Clk);
        m   = model(f, int'(r));
        m.t = $time;
        q.push_back(m);
        #1 Start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge Clk);
            n++;
        end
        check("drain_timeout", 32'(q.size()), 32'd0);
        q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_fixed"}, OutFixed, 32'h0);
        check({tag, "_done"},  {31'b0, OutDone}, 32'd0);
        check({tag, "_busy"},  {31'b0, OutBusy}, 32'd0);
        check({tag, "_flags"}, {29'b0, OutException, OutZero, OutOverflow}, 32'd0);
    endtask

    initial begin
        vecs[0]  = '{32'h3FC0_0000, 6'd16, 32'h0001_8000};
        vecs[1]  = '{32'hBFC0_0000, 6'd16, 32'hFFFE_8000};
        vecs[2]  = '{32'h4980_0000, 6'd16, 32'h7FFF_FFFF};
        vecs[3]  = '{32'hC980_0000, 6'd16, 32'h8000_0000};
        vecs[4]  = '{32'h7F80_0000, 6'd16, 32'h0000_0000};
        vecs[5]  = '{32'h7FC0_0001, 6'd16, 32'h0000_0000};
        vecs[6]  = '{32'h0000_0001, 6'd16, 32'h0000_0000};
        vecs[7]  = '{32'h8000_0000, 6'd16, 32'h0000_0000};
        vecs[8]  = '{32'h3F80_0000, 6'd0,  32'h0000_0001};
        vecs[9]  = '{32'h3F00_0000, 6'd0,  32'h0000_0000};
        vecs[10] = '{32'h4680_0000, 6'd16, 32'h4000_0000};
        vecs[11] = '{32'hC680_0000, 6'd16, 32'hC000_0000};
        vecs[12] = '{32'h4700_0000, 6'd16, 32'h7FFF_FFFF};
        vecs[13] = '{32'h4300_0000, 6'd16, 32'h0080_0000};
        vecs[14] = '{32'h4050_0000, 6'd4,  32'h0000_0034};
        vecs[15] = '{32'hBFC0_0000, 6'd0,  32'hFFFF_FFFF};

        repeat (3) @(posedge Clk);
        #1 check_all_zero("reset");
        @(negedge Clk);
        Rst = 1'b0;
        running = 1'b1;

        // Hand-computed latencies and flags pin the model on the headline cases.
        check("model_lat_1p5",   32'(model(32'h3FC0_0000, 16).lat), 32'd9);
        check("model_ovf_2p20",  {31'b0, model(32'h4980_0000, 16).ovf}, 32'd1);
        check("model_exc_nan",   {31'b0, model(32'h7FC0_0001, 16).exc}, 32'd1);
        check("model_zero_den",  {31'b0, model(32'h0000_0001, 16).zero}, 32'd1);
        check("model_uflow_flg", {31'b0, model(32'h3F00_0000, 0).zero}, 32'd0);

        foreach (vecs[i]) begin
            check($sformatf("model_%0d", i), model(vecs[i].f, int'(vecs[i].r)).fixed, vecs[i].lit);
            start(vecs[i].f, vecs[i].r);
            wait_idle();
            #1 check($sformatf("lit_%0d", i), OutFixed, vecs[i].lit);
        end

        // A Start pulse during SHIFT must neither change nor queue a result.
        start(32'h3FC0_0000, 6'd16);
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        Start = 1'b1; InFloat = 32'h4980_0000; InRadixPoint = 6'd16;
        @(negedge Clk);
        Start = 1'b0;
        wait_idle();
        #1 check("ignored_start_fixed", OutFixed, 32'h0001_8000);
        check("ignored_start_ovf", {31'b0, OutOverflow}, 32'd0);
        repeat (12) @(posedge Clk);

        // Reset in the fourth SHIFT cycle aborts the conversion with no OutDone.
        start(32'h3FC0_0000, 6'd16);
        repeat (4) @(posedge Clk);
        @(negedge Clk);
        #2 Rst = 1'b1;
        q.delete();
        #1 check_all_zero("midreset");
        repeat (2) @(negedge Clk);
        #2 Rst = 1'b0;
        repeat (30) @(posedge Clk);
        #1 check_all_zero("post_reset");

        start(32'h3FC0_0000, 6'd16);
        wait_idle();
        #1 check("restart_fixed", OutFixed, 32'h0001_8000);
        repeat (3) @(posedge Clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
